conv3x3_mac_pe: RTL and testbench
=================================

CONV3X3_MAC_PE -- requirements
Module: conv3x3_mac_pe

Interface
REQ-001 Parameter DATA_W, default 9, signed activation width per tap.
REQ-002 Parameter KER_W, default 16, signed kernel weight width per tap.
REQ-003 Parameter TAPS, default 9, number of parallel multiply taps (3x3 window).
REQ-004 Parameter ACC_W, default 32, signed accumulator width; SHALL be at least DATA_W+KER_W+ceil(log2(TAPS)).
REQ-005 Parameter OUT_W, default 16, signed result width.
REQ-006 Parameter SHIFT, default 8, arithmetic right shift applied before saturation.
REQ-007 Parameter CH_MAX, default 512, maximum input-channel beats per accumulation group.
REQ-008 Parameter RELU_EN, default 1, 1 = clamp negative results to 0.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 in_valid  in  1  input beat valid.
REQ-012 in_ready  out  1  block can accept a beat.
REQ-013 in_last  in  1  beat is the last input channel of the group.
REQ-014 data  in  TAPS*DATA_W  packed signed activations; tap i at [i*DATA_W +: DATA_W].
REQ-015 kernel  in  TAPS*KER_W  packed signed weights; same packing.
REQ-016 bias  in  ACC_W  signed bias, sampled only on the in_last beat.
REQ-017 out_valid  out  1  result valid.
REQ-018 out_ready  in  1  downstream accepts the result.
REQ-019 out_data  out  OUT_W  signed post-processed result.
REQ-020 err_len  out  1  sticky: a group hit CH_MAX beats without in_last.

Function
REQ-021 A beat is accepted when in_valid && in_ready; out handshake completes when out_valid && out_ready.
REQ-022 stall = out_valid && !out_ready; in_ready SHALL equal !stall; every pipeline register holds while stall is high.
REQ-023 Stage 1: register the TAPS full-precision signed products (DATA_W+KER_W bits each), plus valid, last and bias.
REQ-024 Stage 2: register the signed sum of all products, sign-extended to ACC_W; no intermediate truncation.
REQ-025 Stage 3: acc <= acc + sum on non-last beats; on a last beat, result = acc + sum + bias, loaded into the output register, and acc <= 0 in the same cycle.
REQ-026 Latency: a last beat accepted at cycle N raises out_valid at N+3 when no stall occurs.
REQ-027 Post-processing: arithmetic right shift by SHIFT (floor), then, if RELU_EN, negative -> 0, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-028 Accumulator addition wraps modulo 2^ACC_W; there is no accumulator saturation.
REQ-029 A beat counter counts accepted beats per group, clears on in_last, and reaches at most CH_MAX.
REQ-030 When the CH_MAX-th beat of a group arrives without in_last, it SHALL be treated as last (result emitted) and err_len set; err_len clears only on reset.
REQ-031 out_valid clears on handshake unless a new result is loaded in the same cycle; back-to-back groups of one beat each sustain one result per cycle with out_ready held high.
REQ-032 Single-beat group (in_last on the first beat): result = sum + bias.
REQ-033 out_data and out_valid are driven from registers only; no combinational input-to-output path except in_ready from out_ready.

Reset
REQ-034 While reset is low: out_valid=0, out_data=0, err_len=0, acc=0, beat counter=0, all stage valids=0; in_ready=1.
REQ-035 Reset asserted mid-group discards the partial accumulation; the first beat after release starts a new group.

Verification
REQ-036 One beat, all data=1, all kernel=2, bias=0, SHIFT=0, in_last=1 -> out_data=18 three cycles later.
REQ-037 Three beats, data=10, kernel=-1 on all taps, bias=5, SHIFT=0, RELU_EN=1 -> raw -265, out_data=0; RELU_EN=0 -> out_data=-265.
REQ-038 data=255, kernel=32767 on all taps, SHIFT=0, OUT_W=16 -> out_data=32767 (saturated).
REQ-039 out_ready=0 for 5 cycles with a result pending -> out_data stable, in_ready=0, no beat lost; stream resumes in order.
REQ-040 CH_MAX=4, send 4 beats without in_last -> result emitted after the 4th beat, err_len=1 and staying 1.
REQ-041 Assert reset after 2 beats of a group, release, then send 1 beat (data=1, kernel=1, bias=0, in_last=1) -> out_data=9.

Source files
------------

// File: rtl/conv3x3_mac_pe.sv
// conv3x3_mac_pe: 3x3 convolution multiply-accumulate processing element.
// Three register stages (products, tap sum, channel accumulation/output)
// with a single output-side stall that freezes the whole pipeline.
// Results are shifted, optionally ReLU-clamped, and saturated to OUT_W.
module conv3x3_mac_pe #(
    parameter int DATA_W  = 9,
    parameter int KER_W   = 16,
    parameter int TAPS    = 9,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8,
    parameter int CH_MAX  = 512,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [TAPS*DATA_W-1:0]   data,
    input  logic [TAPS*KER_W-1:0]    kernel,
    input  logic [ACC_W-1:0]         bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     err_len
);

    localparam int PW    = DATA_W + KER_W;
    localparam int CNT_W = $clog2(CH_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CH_MAX - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // handshake / group tracking
    logic             stall;
    logic             accept;
    logic             force_last;
    logic             eff_last;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_len_q, err_len_d;

    // stage 1: per-tap products
    logic signed [PW-1:0]    prod_q [TAPS];
    logic signed [PW-1:0]    prod_d [TAPS];
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;
    logic signed [ACC_W-1:0] s1_bias_q, s1_bias_d;

    // stage 2: tap sum
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_last_q, s2_last_d;
    logic signed [ACC_W-1:0] s2_bias_q, s2_bias_d;

    // stage 3: accumulator and output register
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic signed [ACC_W-1:0] result;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] rectified;
    logic signed [ACC_W-1:0] clipped;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = !stall;
    assign accept     = in_valid && in_ready;
    assign force_last = (cnt_q == CNT_LAST);
    // a group reaching CH_MAX beats is closed as if in_last had been seen
    assign eff_last   = in_last || force_last;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err_len    = err_len_q;

    // beat counter and sticky overlength flag
    always_comb begin
        cnt_d     = cnt_q;
        err_len_d = err_len_q;
        if (accept) begin
            cnt_d = eff_last ? '0 : cnt_q + 1'b1;
            if (force_last && !in_last) begin
                err_len_d = 1'b1;
            end
        end
    end

    // stage 1: full-precision products; bias captured only on the closing beat
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_bias_d  = s1_bias_q;
        for (int unsigned i = 0; i < TAPS; i++) begin
            prod_d[i] = prod_q[i];
        end
        if (!stall) begin
            s1_valid_d = accept;
            s1_last_d  = eff_last;
            s1_bias_d  = (accept && eff_last) ? signed'(bias) : '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                prod_d[i] = PW'($signed(data[i*DATA_W +: DATA_W])) *
                            PW'($signed(kernel[i*KER_W +: KER_W]));
            end
        end
    end

    // stage 2: sign-extended sum of all taps
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_bias_d  = s2_bias_q;
        sum_d      = sum_q;
        if (!stall) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_bias_d  = s1_bias_q;
            sum_d      = '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                sum_d = sum_d + ACC_W'(prod_q[i]);
            end
        end
    end

    // stage 3: accumulate, close group, post-process into the output register
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        result      = acc_q + sum_q + s2_bias_q;
        shifted     = result >>> SHIFT;
        rectified   = (RELU_EN != 0 && shifted[ACC_W-1]) ? '0 : shifted;
        if (rectified > SAT_MAX) begin
            clipped = SAT_MAX;
        end else if (rectified < SAT_MIN) begin
            clipped = SAT_MIN;
        end else begin
            clipped = rectified;
        end
        // not stalled implies any held result is being taken this cycle
        if (!stall) begin
            out_valid_d = s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                acc_d = s2_last_q ? '0 : acc_q + sum_q;
                if (s2_last_q) begin
                    out_data_d = clipped[OUT_W-1:0];
                end
            end
        end
    end

    // all state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            err_len_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_bias_q   <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_bias_q   <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            err_len_q   <= err_len_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_bias_q   <= s1_bias_d;
            for (int unsigned i = 0; i < TAPS; i++) begin
                prod_q[i] <= prod_d[i];
            end
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_bias_q   <= s2_bias_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_pe.sv
// Directed bench for conv3x3_mac_pe: three instances share the input stream.
//   dut0: SHIFT=0, RELU on,  CH_MAX=4
//   dut1: SHIFT=0, RELU off, CH_MAX=512
//   dut2: SHIFT=8, RELU off, CH_MAX=512
module tb_conv3x3_mac_pe;

    localparam int DW = 9;
    localparam int KW = 16;
    localparam int TP = 9;
    localparam int AW = 32;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_last;
    logic [TP*DW-1:0]     data;
    logic [TP*KW-1:0]     kernel;
    logic [AW-1:0]        bias;
    logic                 out_ready;

    logic                 in_ready0, in_ready1, in_ready2;
    logic                 out_valid0, out_valid1, out_valid2;
    logic signed [OW-1:0] out_data0, out_data1, out_data2;
    logic                 err_len0, err_len1, err_len2;

    conv3x3_mac_pe #(.SHIFT(0), .RELU_EN(1), .CH_MAX(4)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .data(data), .kernel(kernel), .bias(bias),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .err_len(err_len0));

    conv3x3_mac_pe #(.SHIFT(0), .RELU_EN(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .data(data), .kernel(kernel), .bias(bias),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .err_len(err_len1));

    conv3x3_mac_pe #(.SHIFT(8), .RELU_EN(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .data(data), .kernel(kernel), .bias(bias),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .err_len(err_len2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // results collected on completed output handshakes
    int q0[$];
    int q1[$];
    int q2[$];
    int t0[$];

    always @(negedge clk) begin
        if (reset && out_ready) begin
            if (out_valid0) begin q0.push_back(int'(out_data0)); t0.push_back(cyc); end
            if (out_valid1) q1.push_back(int'(out_data1));
            if (out_valid2) q2.push_back(int'(out_data2));
        end
    end

    function automatic logic [TP*DW-1:0] rep_d(input int v);
        logic [TP*DW-1:0] r;
        for (int i = 0; i < TP; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [TP*KW-1:0] rep_k(input int v);
        logic [TP*KW-1:0] r;
        for (int i = 0; i < TP; i++) r[i*KW +: KW] = KW'(v);
        return r;
    endfunction

    task automatic clear_q();
        q0.delete(); q1.delete(); q2.delete(); t0.delete();
    endtask

    // presents the current inputs until accepted; called at posedge+1
    task automatic send_raw();
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        in_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input int d, input int k, input int b, input bit last);
        data    = rep_d(d);
        kernel  = rep_k(k);
        bias    = AW'(b);
        in_last = last;
        send_raw();
    endtask

    task automatic wait_n(input int n);
        int w;
        w = 0;
        while (q0.size() < n && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("wait_results", q0.size(), n);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid0, 0);
        check({tag, "_out_data"},  out_data0,  0);
        check({tag, "_err_len"},   err_len0,   0);
        check({tag, "_in_ready"},  in_ready0,  1);
    endtask

    initial begin
        int lat;
        int w;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        data      = '0;
        kernel    = '0;
        bias      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single beat 1*2*9 = 18, latency 3
        clear_q();
        send(1, 2, 0, 1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid0 && lat < 10);
        check("latency", lat, 3);
        @(posedge clk);
        #1;
        wait_n(1);
        check("ones_d0", q0[0], 18);
        check("ones_d1", q1[0], 18);
        check("ones_d2", q2[0], 0);

        // three beats of -90, bias 5 on last only -> -265
        clear_q();
        send(10, -1, 999, 0);
        send(10, -1, 999, 0);
        send(10, -1, 5, 1);
        wait_n(1);
        check("neg_relu_d0", q0[0], 0);
        check("neg_raw_d1",  q1[0], -265);
        check("neg_floor_d2", q2[0], -2);

        // positive saturation: 255*32767*9
        clear_q();
        send(255, 32767, 0, 1);
        wait_n(1);
        check("satp_d0", q0[0], 32767);
        check("satp_d1", q1[0], 32767);
        check("satp_d2", q2[0], 32767);

        // negative saturation: -256*32767*9
        clear_q();
        send(-256, 32767, 0, 1);
        wait_n(1);
        check("satn_d0", q0[0], 0);
        check("satn_d1", q1[0], -32768);
        check("satn_d2", q2[0], -32768);

        // distinct taps: sum (i+1)*(i-4) = 60, plus bias 1000
        clear_q();
        for (int i = 0; i < TP; i++) begin
            data[i*DW +: DW]   = DW'(i + 1);
            kernel[i*KW +: KW] = KW'(i - 4);
        end
        bias    = AW'(1000);
        in_last = 1'b1;
        send_raw();
        wait_n(1);
        check("taps_d0", q0[0], 1060);
        check("taps_d1", q1[0], 1060);
        check("taps_d2", q2[0], 4);

        // back-to-back single-beat groups, one result per cycle
        clear_q();
        for (int v = 1; v <= 4; v++) send(v, 1, 0, 1);
        wait_n(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_val%0d", i), q0[i], 9 * (i + 1));
            check($sformatf("b2b_cyc%0d", i), t0[i] - t0[0], i);
        end

        // downstream stall for 5 cycles with a result pending
        clear_q();
        out_ready = 1'b0;
        send(1, 2, 0, 1);
        send(1, 1, 0, 1);
        send(0, 0, 100, 1);
        w = 0;
        while (!out_valid0 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("stall_valid_seen", out_valid0, 1);
        fork
            send(0, 0, 7, 1);
            begin
                for (int i = 0; i < 5; i++) begin
                    check("stall_in_ready", in_ready0, 0);
                    check("stall_out_data", out_data0, 18);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_n(4);
        check("stall_r0", q0[0], 18);
        check("stall_r1", q0[1], 9);
        check("stall_r2", q0[2], 100);
        check("stall_r3", q0[3], 7);
        check("stall_d1_r3", q1[3], 7);

        // overlength group on dut0 (CH_MAX=4)
        check("err_before", err_len0, 0);
        clear_q();
        for (int i = 0; i < 4; i++) send(1, 1, 0, 0);
        wait_n(1);
        check("err_result", q0[0], 36);
        check("err_set", err_len0, 1);
        check("err_d1_clear", err_len1, 0);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", err_len0, 1);

        // reset mid-group discards the partial sum
        send(5, 5, 0, 0);
        send(5, 5, 0, 0);
        reset = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_q();
        send(1, 1, 0, 1);
        wait_n(1);
        check("post_rst_d0", q0[0], 9);
        check("post_rst_d1", q1[0], 9);
        check("post_rst_d2", q2[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
